// File: rtl/seg_pkg.sv
// seg_pkg: shared segment patterns, digit count, scan states and BCD helper
package seg_pkg;
  localparam int NDIG = 4;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  typedef enum logic {ST_BLANK, ST_SHOW} scan_t;
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] res;
    logic c;
    res = v;
    c = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) res[4*i +: 4] = 4'd0;
        else begin
          res[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: BCD digit to active-high a..g segment pattern, dark for 10-15
module seg7_dec
  import seg_pkg::*;
(
  input  logic [3:0] d,
  output logic [6:0] m
);
  // one pattern per legal digit; non-decimal codes stay dark
  always_comb begin
    m = SEG_BLANK;
    case (d)
      4'd0: m = SEG_0;
      4'd1: m = SEG_1;
      4'd2: m = SEG_2;
      4'd3: m = SEG_3;
      4'd4: m = SEG_4;
      4'd5: m = SEG_5;
      4'd6: m = SEG_6;
      4'd7: m = SEG_7;
      4'd8: m = SEG_8;
      4'd9: m = SEG_9;
      default: m = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit BCD counter with multiplexed, snapshot-stable 7-segment scan
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        e,
  input  logic        r,
  input  logic        inc,
  input  logic        clr,
  input  logic        lzb,
  output logic [15:0] s,
  output logic        co,
  output logic [3:0]  an,
  output logic [6:0]  m
);
  localparam int CW = 21;
  scan_t st, st_n;
  logic [1:0] idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [15:0] q;
  logic last, lz, wrap;
  logic [3:0] dig;
  logic [6:0] seg;
  // BCD counter with wrap pulse; clear and reset both suppress the pulse
  always_ff @(posedge e) begin
    if (r || clr) begin
      s <= '0;
      co <= 1'b0;
    end else begin
      if (inc) s <= bcd_inc(s);
      co <= inc && s == 16'h9999;
    end
  end
  // scan state, digit index, phase counter and per-frame snapshot
  always_ff @(posedge e) begin
    if (r) begin
      st <= ST_BLANK;
      idx <= 2'd0;
      cnt <= '0;
      q <= '0;
    end else begin
      st <= st_n;
      idx <= idx_n;
      cnt <= cnt_n;
      if (wrap) q <= s;
    end
  end
  // phase sequencing: BLANK then SHOW per digit, advancing the digit after SHOW
  always_comb begin
    last = cnt == (st == ST_SHOW ? CW'(SCAN_DIV - 1) : CW'(BLANK_CYC - 1));
    st_n = last ? (st == ST_SHOW ? ST_BLANK : ST_SHOW) : st;
    cnt_n = last ? '0 : cnt + CW'(1);
    idx_n = (last && st == ST_SHOW) ? idx + 2'd1 : idx;
    wrap = last && st == ST_SHOW && idx == 2'd3;
  end
  // digit select and leading-zero test, all from registered state except lzb
  always_comb begin
    dig = q[{idx, 2'b00} +: 4];
    lz = lzb && (idx == 2'd3 ? q[15:12] == 4'd0 :
                 idx == 2'd2 ? q[15:8] == 8'd0 :
                 idx == 2'd1 ? q[15:4] == 12'd0 : 1'b0);
    an = st == ST_SHOW ? ~(4'b0001 << idx) : 4'b1111;
    m = (st == ST_SHOW && !lz) ? seg : SEG_BLANK;
  end
  seg7_dec u_dec (.d(dig), .m(seg));
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed stimulus with a cycle-stamped scoreboard for seg_scan_ctrl
module tb_seg_scan_ctrl;
  localparam int SD = 5;
  localparam int BC = 2;
  localparam int FR = 4 * (SD + BC);
  typedef struct {
    int cyc;
    string nm;
    bit disp;
    logic [3:0] an;
    logic [6:0] m;
    logic [15:0] s;
    logic co;
  } exp_t;
  logic e, r, inc, clr, lzb;
  logic [15:0] s;
  logic co;
  logic [3:0] an;
  logic [6:0] m;
  int cyc = 0;
  int rel = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t x;
  logic [6:0] segtab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
  seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .e(e), .r(r), .inc(inc), .clr(clr), .lzb(lzb), .s(s), .co(co), .an(an), .m(m)
  );
  initial begin
    e = 1'b0;
    forever #5 e = ~e;
  end
  always @(posedge e) cyc <= cyc + 1;
  // monitor: compare every expectation stamped for the current cycle
  always @(negedge e) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      x = sb.pop_front();
      checks++;
      if (x.cyc != cyc || s !== x.s || co !== x.co || (x.disp && (an !== x.an || m !== x.m))) begin
        errors++;
        $display("FAIL %s cyc=%0d/%0d got an=%b m=%b s=%h co=%b want an=%b m=%b s=%h co=%b",
                 x.nm, cyc, x.cyc, an, m, s, co, x.an, x.m, x.s, x.co);
      end
    end
  end
  task automatic tick;
    @(posedge e);
    #1;
  endtask
  task automatic push(string nm, int off, bit disp, logic [3:0] a, logic [6:0] mm, logic [15:0] sv, logic c);
    sb.push_back('{cyc + off, nm, disp, a, mm, sv, c});
  endtask
  function automatic int pos();
    return (cyc - rel) % FR;
  endfunction
  function automatic logic [3:0] f_an(int p);
    return (p % (SD + BC) < BC) ? 4'b1111 : ~(4'b0001 << (p / (SD + BC)));
  endfunction
  function automatic logic [6:0] f_m(int p, logic [15:0] qv, bit lz);
    int d;
    logic [3:0] dg;
    d = p / (SD + BC);
    dg = qv[d*4 +: 4];
    if (p % (SD + BC) < BC) return 7'b0;
    if (lz && d > 0 && (qv >> (4 * d)) == 16'h0) return 7'b0;
    return segtab[dg];
  endfunction
  task automatic frame_from(string nm, int from, logic [15:0] qv, bit lz, logic [15:0] sv);
    for (int p = from; p < FR; p++) push(nm, p - from, 1'b1, f_an(p), f_m(p, qv, lz), sv, 1'b0);
    repeat (FR - from) tick;
  endtask
  task automatic frame(string nm, logic [15:0] qv, bit lz, logic [15:0] sv);
    for (int k = 0; k < FR && pos() != 0; k++) tick;
    frame_from(nm, 0, qv, lz, sv);
  endtask
  task automatic do_reset;
    r = 1'b1;
    tick;
    r = 1'b0;
    rel = cyc;
  endtask
  task automatic pulse_inc(int n);
    inc = 1'b1;
    repeat (n) tick;
    inc = 1'b0;
  endtask
  initial begin
    r = 1'b1;
    inc = 1'b0;
    clr = 1'b0;
    lzb = 1'b0;
    repeat (3) tick;
    push("reset", 0, 1'b1, 4'b1111, 7'b0, 16'h0, 1'b0);
    r = 1'b0;
    rel = cyc;
    frame_from("scan", 0, 16'h0, 1'b0, 16'h0);
    push("scan_wrap", 0, 1'b1, 4'b1111, 7'b0, 16'h0, 1'b0);
    pulse_inc(1234);
    push("cnt1234", 0, 1'b0, 4'b0, 7'b0, 16'h1234, 1'b0);
    tick;
    frame("disp1234", 16'h1234, 1'b0, 16'h1234);
    do_reset;
    lzb = 1'b1;
    pulse_inc(42);
    tick;
    frame("lzb42", 16'h0042, 1'b1, 16'h0042);
    do_reset;
    frame("lzb0", 16'h0, 1'b1, 16'h0);
    lzb = 1'b0;
    do_reset;
    repeat (9) tick;
    pulse_inc(1);
    frame_from("hold_old", 10, 16'h0, 1'b0, 16'h0001);
    frame("show_new", 16'h0001, 1'b0, 16'h0001);
    do_reset;
    pulse_inc(9999);
    push("s9999", 0, 1'b0, 4'b0, 7'b0, 16'h9999, 1'b0);
    pulse_inc(1);
    push("wrap_co", 0, 1'b0, 4'b0, 7'b0, 16'h0, 1'b1);
    tick;
    push("co_once", 0, 1'b0, 4'b0, 7'b0, 16'h0, 1'b0);
    pulse_inc(5);
    push("s5", 0, 1'b0, 4'b0, 7'b0, 16'h0005, 1'b0);
    inc = 1'b1;
    clr = 1'b1;
    tick;
    inc = 1'b0;
    clr = 1'b0;
    push("clr_prio", 0, 1'b0, 4'b0, 7'b0, 16'h0, 1'b0);
    tick;
    push("clr_noco", 0, 1'b0, 4'b0, 7'b0, 16'h0, 1'b0);
    do_reset;
    pulse_inc(777);
    push("s0777", 0, 1'b0, 4'b0, 7'b0, 16'h0777, 1'b0);
    for (int k = 0; k < FR && pos() != 17; k++) tick;
    push("mid_show", 0, 1'b1, 4'b1011, 7'b1110000, 16'h0777, 1'b0);
    r = 1'b1;
    tick;
    push("rst_mid", 0, 1'b1, 4'b1111, 7'b0, 16'h0, 1'b0);
    r = 1'b0;
    rel = cyc;
    frame_from("restart", 0, 16'h0, 1'b0, 16'h0);
    repeat (2) tick;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clock cycles each digit is lit (SHOW); legal range 2..2^20.
REQ-002 Parameter BLANK_CYC, default 4: clock cycles all digits are dark between digits (BLANK); legal range 1..255.
REQ-003 Port e, input, 1: sole clock; all state updates on posedge e.
REQ-004 Port r, input, 1: reset; synchronous and active-high.
REQ-005 Port inc, input, 1: count-up request, sampled each cycle.
REQ-006 Port clr, input, 1: synchronous clear of the count.
REQ-007 Port lzb, input, 1: leading-zero blanking enable.
REQ-008 Port s, output, 16: live 4-digit BCD count; s[3:0] is units, s[15:12] is thousands.
REQ-009 Port co, output, 1: one-cycle pulse on wrap 9999->0000.
REQ-010 Port an, output, 4: digit selects, active-low; an[0] is units.
REQ-011 Port m, output, 7: shared segment bus, active-high; m[6] = a through m[0] = g.

Function
REQ-012 Counter: on a cycle with inc=1 and clr=0, s increments in BCD by one; each digit wraps 9->0 and carries into the next digit.
REQ-013 Counter wrap: at s=9999 with inc=1, s becomes 0000 and co=1 on the following cycle only; co=0 at all other times.
REQ-014 Clear: clr=1 sets s=0000 on the next edge, takes priority over inc, and never asserts co.
REQ-015 Scan FSM: two states, BLANK and SHOW; 2-bit digit index idx; cycle counter cnt.
REQ-016 BLANK: lasts exactly BLANK_CYC cycles, with an=4'b1111 and m=7'b0000000, then goes to SHOW with idx unchanged and cnt=0.
REQ-017 SHOW: lasts exactly SCAN_DIV cycles, with an bit idx low and the others high, then goes to BLANK with idx+1 mod 4 and cnt=0.
REQ-018 Frame period is 4*(SCAN_DIV+BLANK_CYC) cycles; digits are lit in order 0,1,2,3,0,...
REQ-019 Snapshot: a 16-bit register q loads s on the edge where idx wraps 3->0 (entry to BLANK of digit 0); q is held for the whole frame so no frame shows mixed counts.
REQ-020 In SHOW, m is the 7-segment pattern of q digit idx: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-021 Leading-zero blanking: with lzb=1, digit k (k>=1) shows m=0000000 (its an bit still low) when q digits k..3 are all zero; digit 0 is never blanked.
REQ-022 The counter (inc, clr, co) runs independently of the scan FSM; a count change mid-frame appears on the display only after the next snapshot.
REQ-023 an and m are decoded from registered state (FSM, idx, q) with no path from inc, clr or lzb to an or m in the same cycle, except that lzb acts in the same cycle.

Reset
REQ-024 r=1 at an edge sets s=0000, q=0000, co=0, state=BLANK, idx=0, cnt=0; this overrides inc and clr.
REQ-025 While in reset and on the cycle after it, an=4'b1111 and m=0000000; the first SHOW of digit 0 starts BLANK_CYC cycles after r deasserts.
REQ-026 Reset asserted mid-SHOW or mid-count aborts the operation with no co pulse; behaviour resumes per REQ-025.

Structure
REQ-027 Shared package seg_pkg holds the ten segment-pattern constants, the blank pattern, NDIG=4, and the scan-state enumeration.
REQ-028 BCD-to-segment decoding lives in one combinational sub-module, seg7_dec (4-bit in, 7-bit out, 0000000 for codes 10-15), instantiated once on the muxed digit.

Verification (SCAN_DIV=5, BLANK_CYC=2)
REQ-029 Release reset -> an=1111 for exactly 2 cycles, then an=1110 for 5 cycles, then 1111 for 2 cycles, then 1101; 28-cycle frame.
REQ-030 Pulse inc 1234 times from reset -> s=16'h1234; on the next frame, units SHOW m=0110011, tens m=1111001, hundreds m=1101101, thousands m=0110000.
REQ-031 Count to 9999, then inc once -> s=0000 with co high for exactly one cycle; clr and inc together at s=0005 -> s=0000 and co=0.
REQ-032 lzb=1 with q=0042 -> digits 2 and 3 show m=0000000 with an bit low; q=0000 -> only digit 0 shows 1111110.
REQ-033 Change s mid-frame (inc during digit 1 SHOW) -> displayed digits keep the old value until idx wraps 3->0, then show the new value.
REQ-034 Assert r during digit 2 SHOW with s=0777 -> next cycle s=0000, an=1111, m=0000000, co=0; the scan restarts per REQ-029.
